// File: rtl/strength_group_driver_if.sv
// Group/strength monitoring interface between the stimulus driver (master) and the
// downstream strength/format monitor (slave).
interface strength_group_driver_if #(
  parameter int unsigned NSIG = 3
);
  logic            start;
  logic            stop;
  logic [NSIG-1:0] sig_out;
  logic [NSIG-1:0] sig_oe;
  logic            smp_valid;
  logic            smp_ack;
  logic [NSIG-1:0] group;
  logic [15:0]     step_cnt;
  logic            overrun;
  logic            busy;

  modport master (
    input  start, stop, smp_ack,
    output sig_out, sig_oe, smp_valid, group, step_cnt, overrun, busy
  );

  modport slave (
    output start, stop, smp_ack,
    input  sig_out, sig_oe, smp_valid, group, step_cnt, overrun, busy
  );
endinterface

// File: rtl/strength_group_driver.sv
// Periodic strength-group stimulus source with settle/sample handshake.
// Define STRENGTH_GROUP_DRIVER_LFSR_EN to step patterns with a 6-bit LFSR (NSIG=3 only).
module strength_group_driver #(
  parameter int unsigned PERIOD = 15,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned NSIG   = 3
) (
  input logic                     clk,
  input logic                     rst,
  strength_group_driver_if.master bus
);
  localparam int unsigned KW = 2 * NSIG;
  localparam logic [15:0] PeriodLast = 16'(PERIOD - 1);
  localparam logic [15:0] SettleLast = 16'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StSettle, StSample} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d, k_next;
  logic [15:0]     pcnt_q, pcnt_d;
  logic [15:0]     scnt_q, scnt_d;
  logic [15:0]     step_cnt_q, step_cnt_d;
  logic [NSIG-1:0] sig_out_q, sig_out_d;
  logic [NSIG-1:0] sig_oe_q, sig_oe_d;
  logic [NSIG-1:0] group_q, group_d;
  logic            smp_valid_q, smp_valid_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;
  logic            tick;

  if (PERIOD < 2 || PERIOD > 65535) begin : g_period_check
    $error("PERIOD must be in 2..65535");
  end
  if (SETTLE < 1 || SETTLE >= PERIOD) begin : g_settle_check
    $error("SETTLE must satisfy 1 <= SETTLE < PERIOD");
  end

`ifdef STRENGTH_GROUP_DRIVER_LFSR_EN
  localparam logic [KW-1:0] KReset = KW'(1);
  if (NSIG != 3) begin : g_lfsr_width_check
    $error("LFSR pattern mode supports NSIG=3 only");
  end
  // Fibonacci x^6+x^5+1: shift left, feedback from the two top taps.
  assign k_next = {k_q[KW-2:0], k_q[KW-1] ^ k_q[KW-2]};
`else
  localparam logic [KW-1:0] KReset = '0;
  assign k_next = k_q + KW'(1);
`endif

  assign tick = (pcnt_q == PeriodLast);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pcnt_d      = pcnt_q;
    scnt_d      = scnt_q;
    step_cnt_d  = step_cnt_q;
    sig_out_d   = sig_out_q;
    sig_oe_d    = sig_oe_q;
    smp_valid_d = smp_valid_q;
    overrun_d   = overrun_q;

    if (bus.stop && (state_q != StIdle)) begin
      state_d     = StIdle;
      sig_oe_d    = '0;
      smp_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.stop) begin
            state_d   = StRun;
            pcnt_d    = '0;
            overrun_d = 1'b0;
          end
        end
        StRun: begin
          if (tick) begin
            pcnt_d    = '0;
            sig_out_d = k_q[NSIG-1:0];
            sig_oe_d  = ~k_q[KW-1:NSIG];
            k_d       = k_next;
            scnt_d    = '0;
            state_d   = StSettle;
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
        end
        StSettle: begin
          // A tick while a pattern is still in flight is dropped, not queued.
          if (tick) begin
            pcnt_d    = '0;
            overrun_d = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
          if (scnt_q == SettleLast) begin
            smp_valid_d = 1'b1;
            state_d     = StSample;
          end else begin
            scnt_d = scnt_q + 16'd1;
          end
        end
        StSample: begin
          if (tick) begin
            pcnt_d    = '0;
            overrun_d = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
          if (bus.smp_ack) begin
            smp_valid_d = 1'b0;
            step_cnt_d  = step_cnt_q + 16'd1;
            state_d     = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    group_d = sig_out_d & sig_oe_d;
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= KReset;
      pcnt_q      <= '0;
      scnt_q      <= '0;
      step_cnt_q  <= '0;
      sig_out_q   <= '0;
      sig_oe_q    <= '0;
      group_q     <= '0;
      smp_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pcnt_q      <= pcnt_d;
      scnt_q      <= scnt_d;
      step_cnt_q  <= step_cnt_d;
      sig_out_q   <= sig_out_d;
      sig_oe_q    <= sig_oe_d;
      group_q     <= group_d;
      smp_valid_q <= smp_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sig_out   = sig_out_q;
  assign bus.sig_oe    = sig_oe_q;
  assign bus.group     = group_q;
  assign bus.smp_valid = smp_valid_q;
  assign bus.step_cnt  = step_cnt_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_strength_group_driver.sv
// Directed bench for strength_group_driver: scoreboard of expected patterns, checked
// whenever the driver raises a sample request.
module tb_strength_group_driver;
  localparam int unsigned PERIOD = 15;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned NSIG   = 3;
  localparam int unsigned KW     = 2 * NSIG;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   sc = 0;
  int   n;

  logic [KW-1:0] mk;
  logic [KW-1:0] sb[$];
  logic [KW-1:0] cur;
  logic [KW-1:0] exp_p;

  strength_group_driver_if #(.NSIG(NSIG)) bus ();

  strength_group_driver #(
    .PERIOD(PERIOD),
    .SETTLE(SETTLE),
    .NSIG  (NSIG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KW-1:0] next_k(input logic [KW-1:0] k);
`ifdef STRENGTH_GROUP_DRIVER_LFSR_EN
    return {k[KW-2:0], k[5] ^ k[4]};
`else
    return KW'(k + 1);
`endif
  endfunction

  // Expected {sig_out, sig_oe} for the next applied pattern.
  task automatic push_exp();
    sb.push_back({mk[NSIG-1:0], ~mk[KW-1:NSIG]});
    mk = next_k(mk);
  endtask

  function automatic logic [KW-1:0] obs_pat();
    return {bus.sig_out, bus.sig_oe};
  endfunction

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!bus.smp_valid && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 32'(bus.smp_valid), 32'd1);
    cur = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_pattern"}, 32'(obs_pat()), 32'(cur));
    chk({tag, "_group"}, 32'(bus.group), 32'(cur[KW-1:NSIG] & cur[NSIG-1:0]));
  endtask

  task automatic ack_step(input string tag);
    bus.smp_ack = 1'b1;
    tick();
    bus.smp_ack = 1'b0;
    sc++;
    chk({tag, "_valid_drop"}, 32'(bus.smp_valid), 32'd0);
    chk({tag, "_step_cnt"}, 32'(bus.step_cnt), 32'(sc));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.smp_ack = 1'b0;
`ifdef STRENGTH_GROUP_DRIVER_LFSR_EN
    mk = KW'(1);
`else
    mk = '0;
`endif

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_sig_out", 32'(bus.sig_out), 32'd0);
    chk("rst_sig_oe", 32'(bus.sig_oe), 32'd0);
    chk("rst_group", 32'(bus.group), 32'd0);
    chk("rst_smp_valid", 32'(bus.smp_valid), 32'd0);
    chk("rst_step_cnt", 32'(bus.step_cnt), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // First step: exact latency from the start edge.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    push_exp();
    repeat (PERIOD - 1) tick();
    chk("pre_first_oe", 32'(bus.sig_oe), 32'd0);
    tick();
    chk("first_pattern", 32'(obs_pat()), 32'(sb[0]));
    chk("first_valid_e15", 32'(bus.smp_valid), 32'd0);
    tick();
    chk("first_valid_e16", 32'(bus.smp_valid), 32'd0);
    tick();
    chk("first_valid_e17", 32'(bus.smp_valid), 32'd1);
    wait_valid("s1");
    ack_step("s1");

    // Steps 2..9 with prompt acknowledges.
    for (int i = 2; i <= 9; i++) begin
      push_exp();
      wait_valid($sformatf("s%0d", i));
      ack_step($sformatf("s%0d", i));
    end

    // Withheld ack: a dropped tick sets overrun and does not advance the pattern.
    push_exp();
    wait_valid("ovr");
    repeat (20) tick();
    chk("ovr_overrun", 32'(bus.overrun), 32'd1);
    chk("ovr_valid_held", 32'(bus.smp_valid), 32'd1);
    chk("ovr_pattern_held", 32'(obs_pat()), 32'(cur));
    push_exp();
    bus.smp_ack = 1'b1;
    tick();
    bus.smp_ack = 1'b0;
    sc++;
    chk("ovr_step_cnt", 32'(bus.step_cnt), 32'(sc));
    repeat (6) tick();
    chk("ovr_no_early_change", 32'(obs_pat()), 32'(cur));
    tick();
    chk("ovr_natural_tick", 32'(obs_pat()), 32'(sb[0]));
    wait_valid("ovr_next");
    ack_step("ovr_next");

    // Simultaneous stop and start in SETTLE: stop wins, state retained.
    push_exp();
    n = 0;
    while (obs_pat() == cur && n < 40) begin
      tick();
      n++;
    end
    exp_p = sb.pop_front();
    chk("stop_change_seen", 32'(obs_pat()), 32'(exp_p));
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_sig_oe", 32'(bus.sig_oe), 32'd0);
    chk("stop_valid", 32'(bus.smp_valid), 32'd0);
    chk("stop_group", 32'(bus.group), 32'd0);
    chk("stop_sig_out_kept", 32'(bus.sig_out), 32'(exp_p[KW-1:NSIG]));
    chk("stop_step_cnt_kept", 32'(bus.step_cnt), 32'(sc));
    chk("stop_overrun_kept", 32'(bus.overrun), 32'd1);
    repeat (3) tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_busy", 32'(bus.busy), 32'd1);
    chk("restart_overrun_clr", 32'(bus.overrun), 32'd0);
    push_exp();
    wait_valid("resume");
    ack_step("resume");

    // Reset while a sample request is pending, checked without a clock edge.
    push_exp();
    wait_valid("pre_rst");
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", 32'(bus.smp_valid), 32'd0);
    chk("mid_rst_sig_out", 32'(bus.sig_out), 32'd0);
    chk("mid_rst_sig_oe", 32'(bus.sig_oe), 32'd0);
    chk("mid_rst_group", 32'(bus.group), 32'd0);
    chk("mid_rst_step_cnt", 32'(bus.step_cnt), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
